// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC/instruction memory and decode; gates PCWrite on acceptance.
// Optional FETCH_STATS_EN adds free-running push and stall counters.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PC,
    input  logic [31:0] Instruction,
    input  logic        IDStall,
    input  logic        Flush,
    output logic        PCWrite,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PCPlus4,
`ifdef FETCH_STATS_EN
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
`endif
    output logic        IF_Valid
);

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } entry_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, if_valid;

    assign if_valid = (count_q != '0);
    assign pop      = if_valid & ~IDStall;
    // A full queue still accepts when the head leaves this cycle.
    assign push     = ~Flush & ((count_q < DEPTH_C) | pop);
    assign PCWrite  = push | Flush;

    assign IF_Valid   = if_valid;
    assign IF_Instr   = if_valid ? mem_q[rd_ptr_q].instr    : 32'h0;
    assign IF_PCPlus4 = if_valid ? mem_q[rd_ptr_q].pc_plus4 : 32'h0;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc_plus4: PC + 32'd4, instr: Instruction};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Flush deliberately leaves the statistics untouched.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (push)     fetch_count_d = fetch_count_q + 32'd1;
        if (!PCWrite) stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign FetchCount = fetch_count_q;
    assign StallCount = stall_count_q;
`endif

endmodule
